// File: rtl/keypad_pkg.sv
// Shared PmodKYPD layout: key positions, row/column strobe masks and the
// emulator state encoding. Used by both the scanner decode and the emulator.
package keypad_pkg;

   // Idle level of the active-low row and column lines
   localparam logic [3:0] LINES_RELEASED = 4'b1111;

   // Physical layout, KEY_LAYOUT[row][col], row 0 at the top, col 0 at the left
   localparam logic [3:0] KEY_LAYOUT [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'h0, 4'hF, 4'hE, 4'hD}
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRESS = 2'd1,
      ST_GAP   = 2'd2
   } emu_state_t;

   // Active-low column strobe that selects the column holding this key
   function automatic logic [3:0] key_col_mask(input logic [3:0] code);
      logic [3:0] mask;
      case (code)
         4'h1, 4'h4, 4'h7, 4'h0: mask = 4'b0111;
         4'h2, 4'h5, 4'h8, 4'hF: mask = 4'b1011;
         4'h3, 4'h6, 4'h9, 4'hE: mask = 4'b1101;
         default:                mask = 4'b1110;  // A, B, C, D
      endcase
      return mask;
   endfunction

   // Active-low row return pulled by this key
   function automatic logic [3:0] key_row_mask(input logic [3:0] code);
      logic [3:0] mask;
      case (code)
         4'h1, 4'h2, 4'h3, 4'hA: mask = 4'b0111;
         4'h4, 4'h5, 4'h6, 4'hB: mask = 4'b1011;
         4'h7, 4'h8, 4'h9, 4'hC: mask = 4'b1101;
         default:                mask = 4'b1110;  // 0, F, E, D
      endcase
      return mask;
   endfunction

   // Row lines a held key drives for a given column strobe; anything other
   // than the key's own single-low column leaves the rows released
   function automatic logic [3:0] row_response(input logic [3:0] col_strobe,
                                               input logic [3:0] code);
      return (col_strobe == key_col_mask(code)) ? key_row_mask(code) : LINES_RELEASED;
   endfunction

   // Scanner-side decode: key at a single-low row/column pair, valid flag in bit 4
   function automatic logic [4:0] key_decode(input logic [3:0] row_strobe,
                                             input logic [3:0] col_strobe);
      logic [4:0] result;
      result = 5'd0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (row_strobe == ~(4'b1000 >> r) && col_strobe == ~(4'b1000 >> c))
               result = {1'b1, KEY_LAYOUT[r][c]};
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO of 4-bit key codes with flush. Head word is read
// combinationally so the popping edge can latch the key it removes.
module key_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [3:0]               din,
   output logic [3:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [3:0]        mem [DEPTH];
   logic [AW-1:0]     wr_ptr_reg;
   logic [AW-1:0]     rd_ptr_reg;
   logic [AW:0]       count_reg;
   logic              do_push;
   logic              do_pop;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;
   assign dout    = mem[rd_ptr_reg];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   // Storage array written on accepted pushes
   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= din;
   end

   // Pointer and occupancy tracking; flush empties in one edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad matrix emulator: presses queued keys one at a time for HOLD_CYCLES,
// releases for GAP_CYCLES between them, and answers the scanner's column
// strobes with the held key's row, like a physical PmodKYPD.
module keypad_emulator import keypad_pkg::*; #(
   parameter int FIFO_DEPTH  = 8,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 25_000_000,
   parameter int CNT_W       = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] key_code,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic       flush,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   output logic       pressed,
   output logic [3:0] pressed_key,
   output logic       busy
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   emu_state_t                  state_reg;
   logic [CNT_W-1:0]            cnt_reg;
   logic [3:0]                  sync1_reg;
   logic [3:0]                  sync2_reg;
   logic [3:0]                  rows_reg;
   logic                        pressed_reg;
   logic [3:0]                  pressed_key_reg;

   logic [3:0]                  fifo_dout;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        fifo_push;
   logic                        fifo_pop;
   logic                        cnt_zero;

   assign cnt_zero  = (cnt_reg == '0);
   assign fifo_push = key_valid && !fifo_full;
   // Pop exactly on the edges where the FSM starts a new press
   assign fifo_pop  = !fifo_empty &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_GAP && cnt_zero));

   assign key_ready   = !fifo_full;
   assign busy        = (state_reg != ST_IDLE) || (fifo_count != '0);
   assign rows        = rows_reg;
   assign pressed     = pressed_reg;
   assign pressed_key = pressed_key_reg;

   key_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (key_code),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Two-flop synchronizer for the scanner's column strobes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_reg <= LINES_RELEASED;
         sync2_reg <= LINES_RELEASED;
      end else begin
         sync1_reg <= cols;
         sync2_reg <= sync1_reg;
      end
   end

   // Press/gap sequencer; rows are computed from the next pressed state so
   // they release on the same edge that pressed falls
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         rows_reg        <= LINES_RELEASED;
         pressed_reg     <= 1'b0;
         pressed_key_reg <= 4'h0;
      end else if (flush) begin
         state_reg       <= ST_IDLE;
         cnt_reg         <= '0;
         rows_reg        <= LINES_RELEASED;
         pressed_reg     <= 1'b0;
         pressed_key_reg <= 4'h0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  state_reg       <= ST_PRESS;
                  cnt_reg         <= HOLD_LOAD;
                  pressed_reg     <= 1'b1;
                  pressed_key_reg <= fifo_dout;
                  rows_reg        <= row_response(sync2_reg, fifo_dout);
               end else begin
                  rows_reg        <= LINES_RELEASED;
               end
            end
            ST_PRESS: begin
               if (cnt_zero) begin
                  state_reg       <= ST_GAP;
                  cnt_reg         <= GAP_LOAD;
                  pressed_reg     <= 1'b0;
                  pressed_key_reg <= 4'h0;
                  rows_reg        <= LINES_RELEASED;
               end else begin
                  cnt_reg         <= cnt_reg - 1'b1;
                  rows_reg        <= row_response(sync2_reg, pressed_key_reg);
               end
            end
            ST_GAP: begin
               if (cnt_zero && !fifo_empty) begin
                  state_reg       <= ST_PRESS;
                  cnt_reg         <= HOLD_LOAD;
                  pressed_reg     <= 1'b1;
                  pressed_key_reg <= fifo_dout;
                  rows_reg        <= row_response(sync2_reg, fifo_dout);
               end else if (cnt_zero) begin
                  state_reg       <= ST_IDLE;
                  rows_reg        <= LINES_RELEASED;
               end else begin
                  cnt_reg         <= cnt_reg - 1'b1;
                  rows_reg        <= LINES_RELEASED;
               end
            end
            default: begin
               state_reg       <= ST_IDLE;
               cnt_reg         <= '0;
               rows_reg        <= LINES_RELEASED;
               pressed_reg     <= 1'b0;
               pressed_key_reg <= 4'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with HOLD=4, GAP=2, FIFO depth 4.
module tb_keypad_emulator;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;
   logic       flush;
   logic [3:0] cols;
   logic [3:0] rows;
   logic       pressed;
   logic [3:0] pressed_key;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0] code;
      logic [3:0] cols;
      logic [3:0] exp_rows;
   } vec_t;

   vec_t vecs [14];

   keypad_emulator #(
      .FIFO_DEPTH  (4),
      .HOLD_CYCLES (4),
      .GAP_CYCLES  (2),
      .CNT_W       (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .flush       (flush),
      .cols        (cols),
      .rows        (rows),
      .pressed     (pressed),
      .pressed_key (pressed_key),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] k6 [6];
      logic [3:0] ek;
      logic       ep;

      // Layout vectors: key, column strobe, expected row response
      vecs[0]  = '{4'h5, 4'b1011, 4'b1011};
      vecs[1]  = '{4'h5, 4'b0111, 4'b1111};
      vecs[2]  = '{4'h0, 4'b0111, 4'b1110};
      vecs[3]  = '{4'hD, 4'b1110, 4'b1110};
      vecs[4]  = '{4'hD, 4'b0000, 4'b1111};
      vecs[5]  = '{4'hD, 4'b1111, 4'b1111};
      vecs[6]  = '{4'hD, 4'b1100, 4'b1111};
      vecs[7]  = '{4'h1, 4'b0111, 4'b0111};
      vecs[8]  = '{4'hA, 4'b1110, 4'b0111};
      vecs[9]  = '{4'hF, 4'b1011, 4'b1110};
      vecs[10] = '{4'hE, 4'b1101, 4'b1110};
      vecs[11] = '{4'h9, 4'b1101, 4'b1101};
      vecs[12] = '{4'h4, 4'b0111, 4'b1011};
      vecs[13] = '{4'hC, 4'b1110, 4'b1101};

      // Reset with a push attempt held during reset
      reset = 1'b0; key_valid = 1'b1; key_code = 4'h3; flush = 1'b0; cols = 4'hF;
      repeat (3) step();
      check("reset_rows", {4'h0, rows}, 8'h0F);
      check("reset_pressed", {7'h0, pressed}, 8'h00);
      check("reset_busy", {7'h0, busy}, 8'h00);
      check("reset_key_ready", {7'h0, key_ready}, 8'h01);
      check("reset_pressed_key", {4'h0, pressed_key}, 8'h00);
      key_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) step();
      check("post_reset_busy", {7'h0, busy}, 8'h00);
      check("post_reset_ready", {7'h0, key_ready}, 8'h01);

      // Table-driven layout and column-match checks
      for (int i = 0; i < 14; i++) begin
         flush = 1'b1;
         step();
         flush = 1'b0;
         cols = vecs[i].cols;
         repeat (3) step();
         key_code = vecs[i].code; key_valid = 1'b1;
         step();
         key_valid = 1'b0;
         step();
         $display("vec %0d key %h cols %b rows %b pressed %b", i, vecs[i].code, vecs[i].cols, rows, pressed);
         check("vec_pressed", {7'h0, pressed}, 8'h01);
         check("vec_key", {4'h0, pressed_key}, {4'h0, vecs[i].code});
         check("vec_rows", {4'h0, rows}, {4'h0, vecs[i].exp_rows});
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("flush_idle_busy", {7'h0, busy}, 8'h00);

      // Single key 5: exactly 4 cycles pressed, row released on the falling edge
      cols = 4'b1011;
      repeat (3) step();
      key_code = 4'h5; key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         $display("hold cycle %0d pressed %b rows %b", c, pressed, rows);
         check("hold_pressed", {7'h0, pressed}, 8'h01);
         check("hold_rows", {4'h0, rows}, 8'h0B);
      end
      step();
      check("release_pressed", {7'h0, pressed}, 8'h00);
      check("release_rows", {4'h0, rows}, 8'h0F);
      check("release_key", {4'h0, pressed_key}, 8'h00);
      repeat (3) step();
      check("after_gap_busy", {7'h0, busy}, 8'h00);

      // Six back-to-back pushes into a depth-4 queue; D is dropped
      cols = 4'hF;
      k6[0] = 4'h1; k6[1] = 4'h2; k6[2] = 4'h3; k6[3] = 4'hA; k6[4] = 4'h0; k6[5] = 4'hD;
      for (int j = 0; j < 36; j++) begin
         if (j < 6) begin
            key_valid = 1'b1; key_code = k6[j];
         end else begin
            key_valid = 1'b0;
         end
         step();
         ep = (j >= 1) && ((j - 1) / 6 < 5) && ((j - 1) % 6 < 4);
         ek = ep ? k6[(j - 1) / 6] : 4'h0;
         $display("burst cycle %0d pressed %b key %h ready %b busy %b", j, pressed, pressed_key, key_ready, busy);
         check("burst_pressed", {7'h0, pressed}, {7'h0, ep});
         check("burst_key", {4'h0, pressed_key}, {4'h0, ek});
         if (j == 3) check("burst_ready_3", {7'h0, key_ready}, 8'h01);
         if (j == 4) check("burst_ready_full", {7'h0, key_ready}, 8'h00);
         if (j == 7) check("burst_ready_7", {7'h0, key_ready}, 8'h01);
         if (j == 30) check("burst_busy_gap", {7'h0, busy}, 8'h01);
         if (j == 31) check("burst_busy_done", {7'h0, busy}, 8'h00);
      end

      // Flush in the 2nd press cycle with two keys queued and a concurrent push
      cols = 4'b0111;
      repeat (3) step();
      key_valid = 1'b1; key_code = 4'h7;
      step();
      key_code = 4'h8;
      step();
      key_code = 4'h9;
      step();
      check("pre_flush_pressed", {7'h0, pressed}, 8'h01);
      check("pre_flush_rows", {4'h0, rows}, 8'h0D);
      key_code = 4'hB; flush = 1'b1;
      step();
      key_valid = 1'b0; flush = 1'b0;
      $display("flush pressed %b rows %b busy %b", pressed, rows, busy);
      check("flush_pressed", {7'h0, pressed}, 8'h00);
      check("flush_rows", {4'h0, rows}, 8'h0F);
      check("flush_busy", {7'h0, busy}, 8'h00);
      check("flush_key", {4'h0, pressed_key}, 8'h00);
      repeat (8) step();
      check("flush_no_resume", {7'h0, pressed}, 8'h00);
      check("flush_push_dropped", {7'h0, busy}, 8'h00);

      // Asynchronous reset in the middle of holding key 0
      key_code = 4'h0; key_valid = 1'b1;
      step();
      key_valid = 1'b0;
      step();
      check("pre_reset_rows", {4'h0, rows}, 8'h0E);
      #2;
      reset = 1'b0;
      #1;
      $display("async reset rows %b pressed %b", rows, pressed);
      check("async_rows", {4'h0, rows}, 8'h0F);
      check("async_pressed", {7'h0, pressed}, 8'h00);
      check("async_ready", {7'h0, key_ready}, 8'h01);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) step();
      check("reset_no_resume", {7'h0, pressed}, 8'h00);
      check("reset_no_busy", {7'h0, busy}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
